// File: rtl/alu_pkg.sv
// Shared opcode, flag-index and FSM-state definitions for the ALU arbiter slice.
package alu_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SLL = 3'b101;
    localparam logic [2:0] OP_SRL = 3'b110;
    localparam logic [2:0] OP_SRA = 3'b111;

    localparam int FLG_OVF   = 3;
    localparam int FLG_CARRY = 2;
    localparam int FLG_ZERO  = 1;
    localparam int FLG_NEG   = 0;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/alu.sv
// Combinational ALU: add/sub with carry/overflow, bitwise logic, and shifts
// whose amount saturates at WIDTH-1.
module alu
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_op,
    output logic [WIDTH-1:0] o_y,
    output logic [3:0]       o_flags
);

    localparam int SH_W = $clog2(WIDTH);

    logic [WIDTH:0]     w_sum;
    logic [WIDTH:0]     w_dif;
    logic [SH_W-1:0]    w_shamt;
    logic [WIDTH-1:0]   w_y;
    logic               w_c;
    logic               w_v;

    always_comb begin
        w_sum   = {1'b0, i_a} + {1'b0, i_b};
        w_dif   = {1'b0, i_a} - {1'b0, i_b};
        w_shamt = (i_b >= WIDTH'(WIDTH)) ? SH_W'(WIDTH - 1) : i_b[SH_W-1:0];
        w_y     = '0;
        w_c     = 1'b0;
        w_v     = 1'b0;
        case (i_op)
            OP_ADD: begin
                w_y = w_sum[WIDTH-1:0];
                w_c = w_sum[WIDTH];
                w_v = (i_a[WIDTH-1] == i_b[WIDTH-1]) && (w_y[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_SUB: begin
                // carry out of the extended subtract is the borrow
                w_y = w_dif[WIDTH-1:0];
                w_c = w_dif[WIDTH];
                w_v = (i_a[WIDTH-1] != i_b[WIDTH-1]) && (w_y[WIDTH-1] != i_a[WIDTH-1]);
            end
            OP_AND: w_y = i_a & i_b;
            OP_OR:  w_y = i_a | i_b;
            OP_XOR: w_y = i_a ^ i_b;
            OP_SLL: w_y = i_a << w_shamt;
            OP_SRL: w_y = i_a >> w_shamt;
            OP_SRA: w_y = WIDTH'($signed(i_a) >>> w_shamt);
        endcase
        o_flags            = '0;
        o_flags[FLG_OVF]   = w_v;
        o_flags[FLG_CARRY] = w_c;
        o_flags[FLG_ZERO]  = (w_y == '0);
        o_flags[FLG_NEG]   = w_y[WIDTH-1];
    end

    assign o_y = w_y;

endmodule

// File: rtl/alu_arbiter.sv
// Two-port round-robin front end to a single shared ALU; one operation in
// flight, fixed two-edge latency from accept to response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_op,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_op,
    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_y,
    output logic [3:0]       rsp0_flags,
    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_y,
    output logic [3:0]       rsp1_flags,
    output logic             busy
);

    state_t           r_state;
    logic             r_ptr;
    logic             r_gnt;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [2:0]       r_op;
    logic [WIDTH-1:0] r_y;
    logic [3:0]       r_flags;

    logic             w_idle;
    logic             w_resp;
    logic             w_any;
    logic             w_pick;
    logic             w_rsp_hs;
    logic [WIDTH-1:0] w_y;
    logic [3:0]       w_flags;

    // Pointer only matters on contention; a lone requester always wins.
    assign w_any    = req0_valid | req1_valid;
    assign w_pick   = (req0_valid && req1_valid) ? r_ptr : req1_valid;
    assign w_idle   = (r_state == ST_IDLE) && !rst;
    assign w_resp   = (r_state == ST_RESP) && !rst;
    assign w_rsp_hs = r_gnt ? rsp1_ready : rsp0_ready;

    assign req0_ready = w_idle && w_any && !w_pick;
    assign req1_ready = w_idle && w_any && w_pick;
    assign rsp0_valid = w_resp && !r_gnt;
    assign rsp1_valid = w_resp && r_gnt;
    assign busy       = (r_state != ST_IDLE) && !rst;
    assign rsp0_y     = r_y;
    assign rsp1_y     = r_y;
    assign rsp0_flags = r_flags;
    assign rsp1_flags = r_flags;

    alu #(.WIDTH(WIDTH)) u_alu (
        .i_a     (r_a),
        .i_b     (r_b),
        .i_op    (r_op),
        .o_y     (w_y),
        .o_flags (w_flags)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ptr   <= 1'b0;
            r_gnt   <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_y     <= '0;
            r_flags <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_gnt   <= w_pick;
                        r_ptr   <= !w_pick;
                        r_a     <= w_pick ? req1_a  : req0_a;
                        r_b     <= w_pick ? req1_b  : req0_b;
                        r_op    <= w_pick ? req1_op : req0_op;
                        r_state <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    r_y     <= w_y;
                    r_flags <= w_flags;
                    r_state <= ST_RESP;
                end
                ST_RESP: begin
                    if (w_rsp_hs) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Scoreboard bench for alu_arbiter: transaction-level model predicts grants,
// handshake timing and results; a monitor compares every presented response.
module tb_alu_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_valid = 0, req1_valid = 0;
    logic         req0_ready, req1_ready;
    logic [W-1:0] req0_a = 0, req0_b = 0, req1_a = 0, req1_b = 0;
    logic [2:0]   req0_op = 0, req1_op = 0;
    logic         rsp0_valid, rsp1_valid;
    logic         rsp0_ready = 1, rsp1_ready = 1;
    logic [W-1:0] rsp0_y, rsp1_y;
    logic [3:0]   rsp0_flags, rsp1_flags;
    logic         busy;

    always #5 clk = ~clk;

    alu_arbiter #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_a(req0_a), .req0_b(req0_b), .req0_op(req0_op),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_a(req1_a), .req1_b(req1_b), .req1_op(req1_op),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
        .rsp0_y(rsp0_y), .rsp0_flags(rsp0_flags),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
        .rsp1_y(rsp1_y), .rsp1_flags(rsp1_flags),
        .busy(busy)
    );

    typedef struct {
        int         port;
        logic [7:0] y;
        logic [3:0] f;
    } exp_t;

    exp_t sq[$];
    int   n_chk = 0;
    int   n_pass = 0;

    // pending requester operations, held until the model predicts a grant
    bit   p_v[2];
    int   p_a[2], p_b[2], p_op[2];
    int   fill_pct = 0;
    bit   rnd_rdy = 0;
    bit   fix_rdy[2] = '{1, 1};

    // transaction model: 0 = free, 1 = computing, 2 = result offered
    int   m_phase = 0;
    bit   m_ptr = 0;
    int   m_port = 0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic exp_t ref_op(int port, int op, int a, int b);
        exp_t e;
        int   sa, sbv, r, sh, y;
        bit   c, v;
        sa  = (a >= 128) ? a - 256 : a;
        sbv = (b >= 128) ? b - 256 : b;
        sh  = (b >= 8) ? 7 : b;
        c = 0; v = 0;
        case (op)
            0: begin r = a + b; y = r & 255; c = (r > 255);
                     v = (sa + sbv > 127) || (sa + sbv < -128); end
            1: begin r = a - b; y = r & 255; c = (a < b);
                     v = (sa - sbv > 127) || (sa - sbv < -128); end
            2: y = a & b;
            3: y = a | b;
            4: y = a ^ b;
            5: y = (a << sh) & 255;
            6: y = a >> sh;
            default: y = (sa >>> sh) & 255;
        endcase
        e.port = port;
        e.y    = y[7:0];
        e.f    = {v, c, (y == 0), y[7]};
        return e;
    endfunction

    task automatic set_op(int p, int op, int a, int b);
        p_v[p] = 1; p_op[p] = op; p_a[p] = a; p_b[p] = b;
    endtask

    task automatic drive(int p, bit v, int op, int a, int b);
        if (p == 0) begin
            req0_valid = v; req0_op = op[2:0]; req0_a = a[7:0]; req0_b = b[7:0];
        end else begin
            req1_valid = v; req1_op = op[2:0]; req1_a = a[7:0]; req1_b = b[7:0];
        end
    endtask

    task automatic model_step();
        bit er[2];
        bit ev[2];
        int cur;
        int g;
        er = '{0, 0};
        ev = '{0, 0};
        cur = m_phase;
        if (cur == 0) begin
            if (p_v[0] || p_v[1]) begin
                g = (p_v[0] && p_v[1]) ? int'(m_ptr) : (p_v[1] ? 1 : 0);
                er[g] = 1;
                sq.push_back(ref_op(g, p_op[g], p_a[g], p_b[g]));
                m_ptr   = (g == 0);
                p_v[g]  = 0;
                m_port  = g;
                m_phase = 1;
            end
        end else if (cur == 1) begin
            m_phase = 2;
        end else begin
            ev[m_port] = 1;
            if ((m_port == 0) ? rsp0_ready : rsp1_ready) m_phase = 0;
        end
        chk("req0_ready", req0_ready, er[0]);
        chk("req1_ready", req1_ready, er[1]);
        chk("rsp0_valid", rsp0_valid, ev[0]);
        chk("rsp1_valid", rsp1_valid, ev[1]);
        chk("busy", busy, cur != 0);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        for (int p = 0; p < 2; p++) begin
            if (!p_v[p] && $urandom_range(0, 99) < fill_pct)
                set_op(p, $urandom_range(0, 7), $urandom_range(0, 255),
                       $urandom_range(0, 1) ? $urandom_range(0, 12) : $urandom_range(0, 255));
            // operands only matter at an accept edge; scramble them otherwise
            if (p_v[p] && m_phase == 0) drive(p, 1, p_op[p], p_a[p], p_b[p]);
            else drive(p, p_v[p], $urandom_range(0, 7), $urandom_range(0, 255), $urandom_range(0, 255));
        end
        rsp0_ready = rnd_rdy ? ($urandom_range(0, 99) < 70) : fix_rdy[0];
        rsp1_ready = rnd_rdy ? ($urandom_range(0, 99) < 70) : fix_rdy[1];
        @(negedge clk);
        model_step();
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1;
        for (int p = 0; p < 2; p++) drive(p, p_v[p], p_op[p], p_a[p], p_b[p]);
        rsp0_ready = 1; rsp1_ready = 1;
        @(negedge clk);
        chk("rst_req0_ready", req0_ready, 0);
        chk("rst_req1_ready", req1_ready, 0);
        chk("rst_rsp0_valid", rsp0_valid, 0);
        chk("rst_rsp1_valid", rsp1_valid, 0);
        chk("rst_busy", busy, 0);
        @(posedge clk);
        #1;
        rst = 0;
        req0_valid = 0; req1_valid = 0;
        m_phase = 0; m_ptr = 0;
        sq.delete();
    endtask

    task automatic drain();
        int i;
        fill_pct = 0; rnd_rdy = 0; fix_rdy = '{1, 1};
        i = 0;
        while (i < 40 && (m_phase != 0 || p_v[0] || p_v[1])) begin
            step();
            i++;
        end
        chk("drain_done", (m_phase == 0 && !p_v[0] && !p_v[1] && sq.size() == 0), 1);
    endtask

    // monitor: every offered response must match the oldest expectation
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                for (int p = 0; p < 2; p++) begin
                    logic       v, r;
                    logic [7:0] y;
                    logic [3:0] f;
                    v = (p == 0) ? rsp0_valid : rsp1_valid;
                    r = (p == 0) ? rsp0_ready : rsp1_ready;
                    y = (p == 0) ? rsp0_y : rsp1_y;
                    f = (p == 0) ? rsp0_flags : rsp1_flags;
                    if (v) begin
                        if (sq.size() == 0) begin
                            n_chk++;
                            $display("FAIL rsp_unexpected: port %0d valid with no expected result at %0t", p, $time);
                        end else begin
                            chk("rsp_port", p, sq[0].port);
                            chk("rsp_y", y, sq[0].y);
                            chk("rsp_flags", f, sq[0].f);
                            if (r) void'(sq.pop_front());
                        end
                    end
                end
            end
        end
    end

    initial begin
        do_reset();

        // lone ADD 1+2
        set_op(0, 0, 1, 2);
        repeat (5) step();

        // simultaneous requests after reset: port 0 first
        do_reset();
        set_op(0, 0, 127, 1);
        set_op(1, 1, 10, 3);
        repeat (8) step();

        // both ports saturated: grants must alternate
        fill_pct = 100;
        repeat (16) step();
        drain();

        // held response with port 0 waiting
        set_op(1, 1, 3, 10);
        fix_rdy[1] = 0;
        step();
        step();
        set_op(0, 0, 5, 5);
        repeat (5) step();
        fix_rdy[1] = 1;
        repeat (6) step();

        // saturating arithmetic shift and zero result
        set_op(0, 7, 8'h80, 9);
        repeat (4) step();
        set_op(0, 2, 8'hFF, 8'h00);
        repeat (4) step();

        // reset during EXEC discards the op and restores port 0 preference
        set_op(0, 0, 20, 22);
        step();
        set_op(0, 3, 8'h0F, 8'hA0);
        set_op(1, 1, 9, 4);
        do_reset();
        repeat (10) step();
        drain();

        // randomized traffic with random response back-pressure
        do_reset();
        rnd_rdy  = 1;
        fill_pct = 60;
        repeat (400) step();
        drain();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
